alu_sequential: RTL and testbench

Parametrised, multi-cycle successor to the 6-bit combinational ALU: same opcode set and encodings, operand width `W` generic, result `2*W` wide. It is registered at both ends with valid/ready handshakes. MUL, DIV and MOD use an iterative shift-add / restoring-division datapath, which keeps the area independent of `W`². The block sits between the operand/opcode source (switch/UART front-end) and the result display/consumer.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_seq_muldiv.sv | 91 +++++++++
 rtl/alu_sequential.sv | 144 ++++++++++++++
 tb/tb_alu_sequential.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and small helpers for the sequential ALU.
// The opcode values match the original combinational 6-bit ALU.
package alu_pkg;

    localparam logic [3:0] OP_XOR = 4'b0000;
    localparam logic [3:0] OP_SHR = 4'b0001;
    localparam logic [3:0] OP_SHL = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_MOD = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;
    localparam logic [3:0] OP_DIV = 4'b1100;
    localparam logic [3:0] OP_NOT = 4'b1101;
    localparam logic [3:0] OP_AND = 4'b1110;
    localparam logic [3:0] OP_OR  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_divide(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || is_divide(op);
    endfunction

    // Width of an iteration counter that has to reach w-1.
    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one 2W accumulator.
// Results are presented combinationally during the final iteration so the caller can register them on that edge.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    output logic             done_o,
    output logic [W-1:0]     quotient_o,
    output logic [W-1:0]     remainder_o,
    output logic [2*W-1:0]   product_o
);

    localparam int            CW   = cnt_bits(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic              busy_q;
    logic              is_div_q;
    logic [CW-1:0]     cnt_q;
    logic [2*W-1:0]    acc_q;
    logic [W-1:0]      opnd_q;

    logic [W:0]        mul_sum;
    logic [2*W-1:0]    mul_next;
    logic [W:0]        rem_shift;
    logic [W-1:0]      rem_diff;
    logic              div_ge;
    logic [2*W-1:0]    div_next;
    logic [2*W-1:0]    acc_d;

    // MUL: acc = {partial product, remaining multiplier bits}, opnd = multiplicand.
    // DIV: acc = {partial remainder, dividend shifting into quotient}, opnd = divisor.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mul_sum   = '0;
        mul_next  = '0;
        rem_shift = '0;
        rem_diff  = '0;
        div_ge    = 1'b0;
        div_next  = '0;
        acc_d     = acc_q;

        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
        mul_next = {mul_sum, acc_q[W-1:1]};

        rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge    = (rem_shift >= {1'b0, opnd_q});
        // When div_ge holds the true difference is below the divisor, so W bits suffice.
        rem_diff  = rem_shift[W-1:0] - opnd_q;
        div_next  = {(div_ge ? rem_diff : rem_shift[W-1:0]), acc_q[W-2:0], div_ge};

        acc_d = is_div_q ? div_next : mul_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            is_div_q <= is_div_i;
            cnt_q    <= '0;
            acc_q    <= is_div_i ? {{W{1'b0}}, a_i} : {{W{1'b0}}, b_i};
            opnd_q   <= is_div_i ? b_i : a_i;
        end else if (busy_q) begin
            acc_q <= acc_d;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign done_o      = busy_q && (cnt_q == LAST);
    assign product_o   = mul_next;
    assign quotient_o  = div_next[W-1:0];
    assign remainder_o = div_next[2*W-1:W];

endmodule

// File: rtl/alu_sequential.sv
// Multi-cycle ALU with valid/ready handshakes on both sides; single-cycle ops finish on the
// accept edge, MUL/DIV/MOD run W iterations in alu_seq_muldiv.
module alu_sequential
    import alu_pkg::*;
#(
    parameter int W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       instruction,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   result,
    output logic             div_by_zero
);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [W-1:0]      a_q, a_d;
    logic              b_zero_q, b_zero_d;
    logic [2*W-1:0]    result_q, result_d;
    logic              dbz_q, dbz_d;

    logic              md_start;
    logic              md_done;
    logic [W-1:0]      md_quotient;
    logic [W-1:0]      md_remainder;
    logic [2*W-1:0]    md_product;
    logic [2*W-1:0]    iter_result;

    function automatic logic [2*W-1:0] single_cycle(input logic [3:0] op,
                                                    input logic [W-1:0] a,
                                                    input logic [W-1:0] b);
        logic [2*W-1:0] ax;
        logic [2*W-1:0] bx;
        logic [W:0]     bw;
        ax = {{W{1'b0}}, a};
        bx = {{W{1'b0}}, b};
        bw = {1'b0, b};
        case (op)
            OP_ADD:  return ax + bx;
            OP_SUB:  return ax - bx;
            OP_NOT:  return {{W{1'b0}}, ~a};
            OP_AND:  return {{W{1'b0}}, a & b};
            OP_OR:   return {{W{1'b0}}, a | b};
            OP_XOR:  return {{W{1'b0}}, a ^ b};
            OP_SHL:  return (bw >= (W + 1)'(2 * W)) ? '0 : (ax << b);
            OP_SHR:  return (bw >= (W + 1)'(2 * W)) ? '0 : (ax >> b);
            default: return '0;
        endcase
    endfunction

    alu_seq_muldiv #(.W(W)) u_muldiv (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (md_start),
        .is_div_i    (is_divide(instruction)),
        .a_i         (A),
        .b_i         (B),
        .done_o      (md_done),
        .quotient_o  (md_quotient),
        .remainder_o (md_remainder),
        .product_o   (md_product)
    );

    // Divide-by-zero overrides the datapath: DIV saturates the low half, MOD passes A through.
    always_comb begin
        iter_result = md_product;
        if (op_q == OP_DIV) begin
            iter_result = {{W{1'b0}}, (b_zero_q ? {W{1'b1}} : md_quotient)};
        end else if (op_q == OP_MOD) begin
            iter_result = {{W{1'b0}}, (b_zero_q ? a_q : md_remainder)};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_zero_d = b_zero_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        md_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d     = instruction;
                    a_d      = A;
                    b_zero_d = (B == '0);
                    if (is_iterative(instruction)) begin
                        md_start = 1'b1;
                        state_d  = BUSY;
                    end else begin
                        result_d = single_cycle(instruction, A, B);
                        dbz_d    = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    result_d = iter_result;
                    dbz_d    = b_zero_q && is_divide(op_q);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_zero_q <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_zero_q <= b_zero_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_sequential.sv
// Directed-vector bench for alu_sequential at W=6: latency, results, divide-by-zero,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_alu_sequential;
    import alu_pkg::*;

    localparam int W = 6;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       instruction;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   result;
    logic             div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    alu_sequential #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation, scrambles the inputs right after the accept edge and
    // returns the cycle (1 = first cycle after accept) in which out_valid was seen.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        in_valid    = 1'b1;
        instruction = op;
        A           = a;
        B           = b;
        tick();
        in_valid    = 1'b0;
        instruction = 4'($urandom);
        A           = W'($urandom);
        B           = W'($urandom);
        check("in_ready_low_after_accept", {63'd0, in_ready}, 64'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_res, input logic exp_dbz, input int exp_lat);
        int lat;
        check({tag, ":ready"}, {63'd0, in_ready}, 64'd1);
        issue(op, a, b, lat);
        check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ":result"}, 64'(result), 64'(exp_res));
        check({tag, ":dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
        tick();
        check({tag, ":valid_one_cycle"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int lat;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        instruction = 4'b0000;
        A           = '0;
        B           = '0;

        #3;
        check("reset:out_valid", {63'd0, out_valid}, 64'd0);
        check("reset:result", 64'(result), 64'd0);
        check("reset:dbz", {63'd0, div_by_zero}, 64'd0);
        #20 rst_n = 1'b1;
        tick();
        check("post_reset:in_ready", {63'd0, in_ready}, 64'd1);

        // Iterative ops at W+1 = 7 cycles.
        run_op("mul_63x63", OP_MUL, 6'd63, 6'd63, 12'hF81, 1'b0, 7);
        run_op("mul_5x7",   OP_MUL, 6'd5,  6'd7,  12'h023, 1'b0, 7);
        run_op("div_45_7",  OP_DIV, 6'd45, 6'd7,  12'd6,   1'b0, 7);
        run_op("mod_45_7",  OP_MOD, 6'd45, 6'd7,  12'd3,   1'b0, 7);
        run_op("div_7_45",  OP_DIV, 6'd7,  6'd45, 12'd0,   1'b0, 7);
        run_op("mod_7_45",  OP_MOD, 6'd7,  6'd45, 12'd7,   1'b0, 7);
        run_op("div_63_1",  OP_DIV, 6'd63, 6'd1,  12'h03F, 1'b0, 7);
        run_op("div_45_0",  OP_DIV, 6'd45, 6'd0,  12'h03F, 1'b1, 7);
        run_op("mod_45_0",  OP_MOD, 6'd45, 6'd0,  12'd45,  1'b1, 7);

        // Single-cycle ops.
        run_op("add_63_63", OP_ADD, 6'd63, 6'd63, 12'h07E, 1'b0, 1);
        run_op("sub_5_9",   OP_SUB, 6'd5,  6'd9,  12'hFFC, 1'b0, 1);
        run_op("not_5",     OP_NOT, 6'b000101, 6'd0, 12'h03A, 1'b0, 1);
        run_op("and",       OP_AND, 6'h2A, 6'h33, 12'h022, 1'b0, 1);
        run_op("or",        OP_OR,  6'h2A, 6'h33, 12'h03B, 1'b0, 1);
        run_op("xor",       OP_XOR, 6'h2A, 6'h33, 12'h019, 1'b0, 1);
        run_op("shl_1_11",  OP_SHL, 6'd1,  6'd11, 12'h800, 1'b0, 1);
        run_op("shl_1_12",  OP_SHL, 6'd1,  6'd12, 12'h000, 1'b0, 1);
        run_op("shl_63_6",  OP_SHL, 6'd63, 6'd6,  12'hFC0, 1'b0, 1);
        run_op("shr_48_4",  OP_SHR, 6'd48, 6'd4,  12'h003, 1'b0, 1);
        run_op("shr_63_63", OP_SHR, 6'd63, 6'd63, 12'h000, 1'b0, 1);
        run_op("op_0011",   4'b0011, 6'd21, 6'd5, 12'h000, 1'b0, 1);
        run_op("op_0110",   4'b0110, 6'd63, 6'd63, 12'h000, 1'b0, 1);

        // Backpressure: result held, new request not taken until after the handshake.
        out_ready = 1'b0;
        check("bp:ready", {63'd0, in_ready}, 64'd1);
        issue(OP_ADD, 6'd3, 6'd4, lat);
        check("bp:latency", 64'(lat), 64'd1);
        check("bp:result", 64'(result), 64'd7);
        in_valid    = 1'b1;
        instruction = OP_SUB;
        A           = 6'd9;
        B           = 6'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp:hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp:hold_result", 64'(result), 64'd7);
            check("bp:hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp:handshake_valid", {63'd0, out_valid}, 64'd0);
        check("bp:handshake_in_ready", {63'd0, in_ready}, 64'd1);
        check("bp:handshake_result", 64'(result), 64'd7);
        tick();
        in_valid = 1'b0;
        check("bp:second_valid", {63'd0, out_valid}, 64'd1);
        check("bp:second_result", 64'(result), 64'd6);
        check("bp:second_in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        check("bp:second_done", {63'd0, out_valid}, 64'd0);

        // Reset during the third cycle of a MUL.
        check("rst_mul:ready", {63'd0, in_ready}, 64'd1);
        in_valid    = 1'b1;
        instruction = OP_MUL;
        A           = 6'd63;
        B           = 6'd63;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mul:out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mul:result", 64'(result), 64'd0);
        check("rst_mul:dbz", {63'd0, div_by_zero}, 64'd0);
        check("rst_mul:in_ready", {63'd0, in_ready}, 64'd1);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_mul:no_stale_valid", {63'd0, out_valid}, 64'd0);
        end
        check("rst_mul:result_still_zero", 64'(result), 64'd0);
        run_op("add_10_20", OP_ADD, 6'd10, 6'd20, 12'd30, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
